// File: rtl/fwd_mux_pkg.sv
// Shared types for the forwarding-mux controller: pipeline entry record and the
// per-edge action decoded from freeze/flush/stall priority.
package fwd_mux_pkg;

  localparam int FWD_SEL_REGFILE = 0;

  // Entry destination field width; covers register files of up to 256 entries.
  // The controller zero-extends its REG_W-wide addresses into this field.
  localparam int FWD_MAX_REG_W = 8;

  typedef struct packed {
    logic                     valid;
    logic [FWD_MAX_REG_W-1:0] dest;
    logic                     is_load;
  } fwd_entry_t;

  typedef enum logic [1:0] {
    ACT_HOLD,
    ACT_FLUSH,
    ACT_BUBBLE,
    ACT_SHIFT
  } pipe_action_t;

  function automatic pipe_action_t decode_action(input logic freeze_i,
                                                 input logic flush_i,
                                                 input logic stall_i);
    if (freeze_i) begin
      return ACT_HOLD;
    end else if (flush_i) begin
      return ACT_FLUSH;
    end else if (stall_i) begin
      return ACT_BUBBLE;
    end
    return ACT_SHIFT;
  endfunction

endpackage

// File: rtl/fwd_mux_ctrl_match.sv
// Priority encoder for one decode operand: youngest in-flight producer wins,
// and a load found younger than LOAD_READY flags a load-use hazard.
module fwd_match
  import fwd_mux_pkg::*;
#(
  parameter int DEPTH      = 3,
  parameter int REG_W      = 5,
  parameter int LOAD_READY = 2,
  parameter int SEL_W      = 2
) (
  input  fwd_entry_t [DEPTH:1] entries_i,
  input  logic [REG_W-1:0]     src_i,
  output logic [SEL_W-1:0]     sel_o,
  output logic                 load_hazard_o
);

  logic [FWD_MAX_REG_W-1:0] src_ext;

  assign src_ext = FWD_MAX_REG_W'(src_i);

  // Scan oldest to youngest so the last hit, the smallest stage index, sticks.
  always_comb begin
    sel_o         = SEL_W'(FWD_SEL_REGFILE);
    load_hazard_o = 1'b0;
    if (src_i != '0) begin
      for (int k = DEPTH; k >= 1; k--) begin
        if (entries_i[k].valid && (entries_i[k].dest == src_ext)) begin
          sel_o         = SEL_W'(k);
          load_hazard_o = entries_i[k].is_load && (k < LOAD_READY);
        end
      end
    end
  end

endmodule

// File: rtl/fwd_mux_ctrl.sv
// Operand-source controller: tracks in-flight destinations and drives the ALU
// forwarding selects plus load-use stall. FWD_MUX_STATS_EN adds stall/forward counters.
module fwd_mux_ctrl
  import fwd_mux_pkg::*;
#(
  parameter  int NUM_REGS   = 32,
  parameter  int DEPTH      = 3,
  parameter  int LOAD_READY = 2,
  localparam int REG_W      = $clog2(NUM_REGS),
  localparam int SEL_W      = $clog2(DEPTH + 1)
) (
  input  logic             CLK,
  input  logic             nRST,
  input  logic             freeze,
  input  logic             flush,
  input  logic             issue_valid,
  input  logic             issue_wen,
  input  logic             issue_is_load,
  input  logic [REG_W-1:0] issue_dest,
  input  logic [REG_W-1:0] rs_addr,
  input  logic [REG_W-1:0] rt_addr,
  output logic [SEL_W-1:0] fwd_sel_a,
  output logic [SEL_W-1:0] fwd_sel_b,
  output logic             stall
`ifdef FWD_MUX_STATS_EN
  ,
  output logic [31:0]      stall_cycles,
  output logic [31:0]      fwd_events
`endif
);

  fwd_entry_t [DEPTH:1] entries_q;
  fwd_entry_t [DEPTH:1] entries_d;
  fwd_entry_t           issue_entry;
  pipe_action_t         action;
  logic                 hazard_a;
  logic                 hazard_b;

  fwd_match #(
    .DEPTH      (DEPTH),
    .REG_W      (REG_W),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_a (
    .entries_i     (entries_q),
    .src_i         (rs_addr),
    .sel_o         (fwd_sel_a),
    .load_hazard_o (hazard_a)
  );

  fwd_match #(
    .DEPTH      (DEPTH),
    .REG_W      (REG_W),
    .LOAD_READY (LOAD_READY),
    .SEL_W      (SEL_W)
  ) u_match_b (
    .entries_i     (entries_q),
    .src_i         (rt_addr),
    .sel_o         (fwd_sel_b),
    .load_hazard_o (hazard_b)
  );

  assign stall  = hazard_a | hazard_b;
  assign action = decode_action(freeze, flush, stall);

  // Writes to register 0 are discarded, so they enter the pipe as bubbles.
  always_comb begin
    issue_entry         = '0;
    issue_entry.valid   = issue_valid & issue_wen & (issue_dest != '0);
    issue_entry.dest    = FWD_MAX_REG_W'(issue_dest);
    issue_entry.is_load = issue_is_load;
  end

  always_comb begin
    entries_d = entries_q;
    if (action != ACT_HOLD) begin
      for (int k = DEPTH; k >= 2; k--) begin
        entries_d[k] = entries_q[k-1];
        if ((k == 2) && (action == ACT_FLUSH)) begin
          entries_d[k].valid = 1'b0;
        end
      end
      entries_d[1] = (action == ACT_SHIFT) ? issue_entry : '0;
    end
  end

  always_ff @(posedge CLK) begin
    if (!nRST) begin
      entries_q <= '0;
    end else begin
      entries_q <= entries_d;
    end
  end

`ifdef FWD_MUX_STATS_EN
  logic [31:0] stall_cycles_q;
  logic [31:0] fwd_events_q;
  logic [1:0]  fwd_inc;

  assign fwd_inc = {1'b0, (fwd_sel_a != '0)} + {1'b0, (fwd_sel_b != '0)};

  // Both counters saturate rather than wrap.
  always_ff @(posedge CLK) begin
    if (!nRST) begin
      stall_cycles_q <= '0;
      fwd_events_q   <= '0;
    end else if (!freeze) begin
      if (stall && (stall_cycles_q != 32'hFFFF_FFFF)) begin
        stall_cycles_q <= stall_cycles_q + 32'd1;
      end
      if (!stall && issue_valid) begin
        if (fwd_events_q > (32'hFFFF_FFFF - 32'(fwd_inc))) begin
          fwd_events_q <= 32'hFFFF_FFFF;
        end else begin
          fwd_events_q <= fwd_events_q + 32'(fwd_inc);
        end
      end
    end
  end

  assign stall_cycles = stall_cycles_q;
  assign fwd_events   = fwd_events_q;
`endif

endmodule

// File: tb/tb_fwd_mux_ctrl.sv
// Directed bench for fwd_mux_ctrl: literal per-step expectations plus an
// age-based producer model compared against the DUT on every cycle.
module tb_fwd_mux_ctrl;

  localparam int DEPTH      = 3;
  localparam int LOAD_READY = 2;

  logic       CLK = 1'b0;
  logic       nRST;
  logic       freeze;
  logic       flush;
  logic       issue_valid;
  logic       issue_wen;
  logic       issue_is_load;
  logic [4:0] issue_dest;
  logic [4:0] rs_addr;
  logic [4:0] rt_addr;
  logic [1:0] fwd_sel_a;
  logic [1:0] fwd_sel_b;
  logic       stall;
`ifdef FWD_MUX_STATS_EN
  logic [31:0] stall_cycles;
  logic [31:0] fwd_events;
`endif

  always #5 CLK = ~CLK;

  fwd_mux_ctrl #(
    .NUM_REGS   (32),
    .DEPTH      (DEPTH),
    .LOAD_READY (LOAD_READY)
  ) dut (
    .CLK           (CLK),
    .nRST          (nRST),
    .freeze        (freeze),
    .flush         (flush),
    .issue_valid   (issue_valid),
    .issue_wen     (issue_wen),
    .issue_is_load (issue_is_load),
    .issue_dest    (issue_dest),
    .rs_addr       (rs_addr),
    .rt_addr       (rt_addr),
    .fwd_sel_a     (fwd_sel_a),
    .fwd_sel_b     (fwd_sel_b),
    .stall         (stall)
`ifdef FWD_MUX_STATS_EN
    ,
    .stall_cycles  (stall_cycles),
    .fwd_events    (fwd_events)
`endif
  );

  // Each producer is remembered by its age (edges since issue); age == stage index.
  typedef struct {
    logic [4:0] dest;
    logic       ld;
    int         age;
  } rec_t;

  rec_t inflight[$];
  int   checks  = 0;
  int   fails   = 0;
  bit   checkEn = 1'b0;

  function automatic void modelSel(input logic [4:0] src, output int sel, output bit haz);
    sel = 0;
    haz = 1'b0;
    if (src != 5'd0) begin
      foreach (inflight[i]) begin
        if ((inflight[i].dest == src) && ((sel == 0) || (inflight[i].age < sel))) begin
          sel = inflight[i].age;
          haz = inflight[i].ld && (inflight[i].age < LOAD_READY);
        end
      end
    end
  endfunction

  task automatic checkVal(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Compare against the model mid-cycle, then advance it exactly as the next edge will.
  always @(negedge CLK) begin : compare
    int   sa;
    int   sb;
    bit   ha;
    bit   hb;
    rec_t keep[$];
    modelSel(rs_addr, sa, ha);
    modelSel(rt_addr, sb, hb);
    if (checkEn) begin
      checkVal("model_selA", 32'(fwd_sel_a), 32'(sa));
      checkVal("model_selB", 32'(fwd_sel_b), 32'(sb));
      checkVal("model_stall", 32'(stall), 32'(ha | hb));
    end
    if (!nRST) begin
      inflight.delete();
    end else if (!freeze) begin
      keep.delete();
      foreach (inflight[i]) begin
        if (!(flush && (inflight[i].age == 1)) && (inflight[i].age < DEPTH)) begin
          keep.push_back('{dest: inflight[i].dest, ld: inflight[i].ld, age: inflight[i].age + 1});
        end
      end
      if (!flush && !(ha || hb) && issue_valid && issue_wen && (issue_dest != 5'd0)) begin
        keep.push_back('{dest: issue_dest, ld: issue_is_load, age: 1});
      end
      inflight = keep;
    end
  end

  task automatic applyStimulus(input logic v, input logic wen, input logic ld,
                               input logic [4:0] dest, input logic [4:0] rs,
                               input logic [4:0] rt, input logic frz,
                               input logic fl, input logic rstn);
    @(posedge CLK);
    #2;
    issue_valid   = v;
    issue_wen     = wen;
    issue_is_load = ld;
    issue_dest    = dest;
    rs_addr       = rs;
    rt_addr       = rt;
    freeze        = frz;
    flush         = fl;
    nRST          = rstn;
  endtask

  task automatic checkOutput(input string name, input int expA, input int expB, input int expStall);
    #1;
    checkVal({name, "_selA"}, 32'(fwd_sel_a), 32'(expA));
    checkVal({name, "_selB"}, 32'(fwd_sel_b), 32'(expB));
    checkVal({name, "_stall"}, 32'(stall), 32'(expStall));
  endtask

  initial begin
    nRST          = 1'b0;
    freeze        = 1'b0;
    flush         = 1'b0;
    issue_valid   = 1'b0;
    issue_wen     = 1'b0;
    issue_is_load = 1'b0;
    issue_dest    = 5'd0;
    rs_addr       = 5'd0;
    rt_addr       = 5'd0;
    repeat (2) @(posedge CLK);
    #2;
    checkEn = 1'b1;

    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);  checkOutput("reset", 0, 0, 0);

    applyStimulus(1, 1, 0, 5, 0, 0, 0, 0, 1);  checkOutput("alu5_issue", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 1);  checkOutput("alu5_ex", 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);  checkOutput("alu5_mem_rs0", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 1);  checkOutput("alu5_wb", 3, 0, 0);
    applyStimulus(0, 0, 0, 0, 5, 0, 0, 0, 1);  checkOutput("alu5_gone", 0, 0, 0);

    applyStimulus(1, 1, 1, 8, 0, 0, 0, 0, 1);  checkOutput("load8_issue", 0, 0, 0);
    applyStimulus(1, 1, 0, 10, 0, 8, 0, 0, 1); checkOutput("load8_stall", 0, 1, 1);
    applyStimulus(0, 0, 0, 0, 10, 8, 0, 0, 1); checkOutput("load8_mem", 0, 2, 0);

    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0, 1);  checkOutput("alu3_first", 0, 0, 0);
    applyStimulus(1, 1, 0, 3, 0, 0, 0, 0, 1);  checkOutput("alu3_second", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 3, 3, 0, 0, 1);  checkOutput("alu3_youngest", 1, 1, 0);

    applyStimulus(1, 1, 0, 0, 0, 0, 0, 0, 1);  checkOutput("dest0_issue", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);  checkOutput("dest0_rs0", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1);  checkOutput("drain", 0, 0, 0);

    applyStimulus(1, 1, 1, 9, 0, 0, 0, 0, 1);  checkOutput("load9_issue", 0, 0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus(0, 0, 0, 0, 9, 0, 1, 0, 1); checkOutput("load9_freeze", 1, 0, 1);
    end
    applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, 1);  checkOutput("load9_unfrozen", 1, 0, 1);
    applyStimulus(0, 0, 0, 0, 9, 0, 0, 0, 1);  checkOutput("load9_mem", 2, 0, 0);

    applyStimulus(1, 1, 1, 2, 0, 0, 0, 0, 1);  checkOutput("load2_issue", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 2, 2, 0, 0, 1);  checkOutput("load2_both", 1, 1, 1);
    applyStimulus(0, 0, 0, 0, 2, 2, 0, 0, 1);  checkOutput("load2_both_mem", 2, 2, 0);

    applyStimulus(1, 1, 0, 7, 0, 0, 0, 0, 1);  checkOutput("alu7_issue", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 1, 1);  checkOutput("alu7_flush", 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 1);  checkOutput("alu7_killed", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 1);  checkOutput("alu7_killed2", 0, 0, 0);
    applyStimulus(1, 1, 0, 7, 0, 0, 0, 1, 1);  checkOutput("flush_issue", 0, 0, 0);
    applyStimulus(0, 0, 0, 0, 7, 0, 0, 0, 1);  checkOutput("flush_issue_killed", 0, 0, 0);

    applyStimulus(1, 1, 0, 4, 0, 0, 0, 0, 1);  checkOutput("alu4_issue", 0, 0, 0);
    applyStimulus(1, 1, 0, 6, 4, 0, 0, 0, 1);  checkOutput("alu6_issue", 1, 0, 0);
    applyStimulus(0, 0, 0, 0, 4, 6, 0, 0, 0);  checkOutput("reset_cycle", 2, 1, 0);
    applyStimulus(0, 0, 0, 0, 4, 6, 0, 0, 1);  checkOutput("after_reset", 0, 0, 0);

    @(posedge CLK);
    #6;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule
